// File: rtl/nv_dram_ctrl_p.sv
// nv_dram_ctrl_p: non-volatile DRAM array with a valid/ready command port,
// fixed-latency reads, automatic refresh scheduling and power-down.
// The storage array has no reset so its contents survive rst and power-down.
module nv_dram_ctrl_p #(
  parameter int DW         = 8,
  parameter int ROW_BITS   = 4,
  parameter int COL_BITS   = 4,
  parameter int RD_LAT     = 2,
  parameter int REF_PERIOD = 64,
  parameter int REF_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [2+ROW_BITS+COL_BITS+DW-1:0]   user_data,
  input  logic                                power_enable,
  input  logic [1:0]                          clk_mode,
  output logic [DW-1:0]                       user_out,
  output logic                                rd_valid,
  output logic                                refresh_int,
  output logic                                err
);

  localparam int CW  = 2 + ROW_BITS + COL_BITS + DW;
  localparam int AW  = ROW_BITS + COL_BITS;
  localparam int RDW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int RFW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
  localparam int RCW = $clog2(4 * REF_PERIOD);

  localparam logic [RDW-1:0] RD_LAST = RDW'(RD_LAT - 1);
  localparam logic [RFW-1:0] RF_LAST = RFW'(REF_CYCLES - 1);
  localparam logic [RCW-1:0] LIM0    = RCW'(REF_PERIOD - 1);
  localparam logic [RCW-1:0] LIM1    = RCW'(2 * REF_PERIOD - 1);
  localparam logic [RCW-1:0] LIM2    = RCW'(4 * REF_PERIOD - 1);

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_REFRESH, S_PWRDN} state_t;

  state_t              state_q, state_d;
  logic [RDW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [RFW-1:0]      ref_left_q, ref_left_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic [DW-1:0]       user_out_q, user_out_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;
  logic [RCW-1:0]      ref_cnt_q, ref_cnt_d;
  logic                ref_pending_q, ref_pending_d;
  logic [ROW_BITS-1:0] ref_row_q, ref_row_d;
  logic [RCW-1:0]      ref_limit;
  logic [DW-1:0]       mem_rd_q;

  logic [DW-1:0]       mem [2**AW];

  logic [1:0]          op;
  logic [AW-1:0]       cmd_addr;
  logic [DW-1:0]       cmd_data;
  logic                accept;
  logic                rd_done;
  logic                ref_done;

  assign op       = user_data[CW-1 -: 2];
  assign cmd_addr = user_data[CW-3 -: AW];
  assign cmd_data = user_data[DW-1:0];
  assign accept   = cmd_valid & cmd_ready;
  assign rd_done  = (state_q == S_READ) && (rd_cnt_q == RD_LAST) && power_enable;
  assign ref_done = (state_q == S_REFRESH) && (ref_left_q == RF_LAST) && power_enable;

  // State register and all control/datapath flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rd_cnt_q      <= '0;
      ref_left_q    <= '0;
      rd_addr_q     <= '0;
      user_out_q    <= '0;
      rd_valid_q    <= 1'b0;
      err_q         <= 1'b0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_row_q     <= '0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      ref_left_q    <= ref_left_d;
      rd_addr_q     <= rd_addr_d;
      user_out_q    <= user_out_d;
      rd_valid_q    <= rd_valid_d;
      err_q         <= err_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_row_q     <= ref_row_d;
    end
  end

  // Storage array: write on accept, registered read addressed by the next read address
  always_ff @(posedge clk) begin
    if (accept && (op == OP_WR)) begin
      mem[cmd_addr] <= cmd_data;
    end
    mem_rd_q <= mem[rd_addr_d];
  end

  // Next-state logic; power-down overrides every state, pending refresh beats commands
  always_comb begin
    state_d = state_q;
    if (!power_enable) begin
      state_d = S_PWRDN;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ref_pending_q)                 state_d = S_REFRESH;
          else if (accept && (op == OP_RD))  state_d = S_READ;
        end
        S_READ:    if (rd_cnt_q == RD_LAST)   state_d = S_IDLE;
        S_REFRESH: if (ref_left_q == RF_LAST) state_d = S_IDLE;
        default:                              state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the current state
  always_comb begin
    cmd_ready   = (state_q == S_IDLE) & enable & power_enable & ~ref_pending_q;
    refresh_int = (state_q == S_REFRESH);
  end

  // Refresh interval selected by clk_mode (mode 11 is handled as "off" below)
  always_comb begin
    case (clk_mode)
      2'b00:   ref_limit = LIM0;
      2'b01:   ref_limit = LIM1;
      default: ref_limit = LIM2;
    endcase
  end

  // Datapath next values: read/refresh phase counters, read data, error pulse, scheduler
  always_comb begin
    rd_cnt_d      = (state_q == S_READ) ? rd_cnt_q + RDW'(1) : '0;
    ref_left_d    = (state_q == S_REFRESH) ? ref_left_q + RFW'(1) : '0;
    rd_addr_d     = (accept && (op == OP_RD)) ? cmd_addr : rd_addr_q;
    user_out_d    = rd_done ? mem_rd_q : user_out_q;
    rd_valid_d    = rd_done;
    err_d         = accept && ((op == 2'b00) || (op == 2'b11));
    ref_row_d     = ref_done ? ref_row_q + ROW_BITS'(1) : ref_row_q;
    ref_cnt_d     = ref_cnt_q;
    ref_pending_d = ref_pending_q;
    if (ref_done) begin
      ref_pending_d = 1'b0;
    end
    if (state_q == S_PWRDN) begin
      // Frozen while powered down; restart the interval on wake-up
      if (power_enable) begin
        ref_cnt_d = '0;
      end
    end else if (clk_mode == 2'b11) begin
      ref_cnt_d = '0;
    end else if (ref_cnt_q >= ref_limit) begin
      ref_cnt_d     = '0;
      ref_pending_d = 1'b1;
    end else begin
      ref_cnt_d = ref_cnt_q + RCW'(1);
    end
  end

  assign user_out = user_out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_nv_dram_ctrl_p.sv
// Self-checking bench for nv_dram_ctrl_p: directed scenarios plus randomized
// command traffic checked against an array model of the memory and closed-form
// refresh timing (start every period, lasting REF_CYCLES cycles).
module tb_nv_dram_ctrl_p;
  localparam int DW = 8, RB = 4, CB = 4, RD_LAT = 2, REF_PERIOD = 64, REF_CYCLES = 4;
  localparam int CW = 2 + RB + CB + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] user_data = '0;
  logic          power_enable = 1'b1;
  logic [1:0]    clk_mode = 2'b00;
  logic [DW-1:0] user_out;
  logic          rd_valid;
  logic          refresh_int;
  logic          err;

  always #5 clk = ~clk;

  nv_dram_ctrl_p #(
    .DW(DW), .ROW_BITS(RB), .COL_BITS(CB), .RD_LAT(RD_LAT),
    .REF_PERIOD(REF_PERIOD), .REF_CYCLES(REF_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .user_data(user_data), .power_enable(power_enable), .clk_mode(clk_mode),
    .user_out(user_out), .rd_valid(rd_valid), .refresh_int(refresh_int), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory contents, which cells are known, last returned read data
  logic [DW-1:0] mdl_mem [256];
  bit            mdl_valid [256];
  logic [DW-1:0] mdl_last_rd;
  logic [7:0]    written_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) until cmd_ready is high; caller is just after a negedge
  task automatic wait_ready(output int waited);
    waited = 0;
    #1;
    while (!cmd_ready && waited < 400) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", {31'b0, cmd_ready}, 32'd1);
      waited = -1;
    end
  endtask

  // Present one command, wait for the handshake, then check its visible effect
  task automatic issue(input logic [1:0] op, input logic [3:0] row, input logic [3:0] col,
                       input logic [7:0] data, output int waited);
    logic [7:0] a;
    a = {row, col};
    user_data = {op, row, col, data};
    cmd_valid = 1'b1;
    wait_ready(waited);
    if (waited < 0) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    user_data = CW'($urandom);
    #1;
    case (op)
      2'b01: begin
        mdl_mem[a] = data;
        if (!mdl_valid[a]) written_q.push_back(a);
        mdl_valid[a] = 1'b1;
        check("wr_no_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("wr_user_out_held", {24'b0, user_out}, {24'b0, mdl_last_rd});
        $display("WR  r%0d c%0d <= %02h (waited %0d)", row, col, data, waited);
      end
      2'b10: begin
        for (int k = 0; k <= RD_LAT; k++) begin
          if (k > 0) begin
            @(negedge clk);
            #1;
          end
          check($sformatf("rd_valid_lat%0d", k), {31'b0, rd_valid}, (k == RD_LAT) ? 32'd1 : 32'd0);
        end
        check("rd_data", {24'b0, user_out}, {24'b0, mdl_mem[a]});
        mdl_last_rd = mdl_mem[a];
        @(negedge clk);
        #1;
        check("rd_valid_pulse_end", {31'b0, rd_valid}, 32'd0);
        $display("RD  r%0d c%0d -> %02h (model %02h, waited %0d)", row, col, user_out, mdl_mem[a], waited);
      end
      default: begin
        check("err_pulse", {31'b0, err}, 32'd1);
        @(negedge clk);
        #1;
        check("err_pulse_end", {31'b0, err}, 32'd0);
        $display("BAD op=%0d r%0d c%0d err pulsed", op, row, col);
      end
    endcase
  endtask

  // Assert reset for two cycles checking outputs; returns at "cycle 0" negedge
  task automatic do_reset(input logic [1:0] mode);
    @(negedge clk);
    clk_mode = mode;
    cmd_valid = 1'b0;
    enable = 1'b1;
    power_enable = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_user_out", {24'b0, user_out}, 32'd0);
      check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      check("rst_refresh_int", {31'b0, refresh_int}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    mdl_last_rd = '0;
    $display("RST mode=%0d", mode);
  endtask

  // Idle refresh timing from reset for a given mode
  task automatic ref_window(input int mode, input int ncyc);
    int per;
    bit exp_ri, exp_rdy;
    int starts;
    per = REF_PERIOD << mode;
    starts = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      #1;
      exp_ri  = (mode != 3) && (k >= per + 1) && (((k - per - 1) % per) < REF_CYCLES);
      exp_rdy = !((mode != 3) && (k >= per) && (((k - per) % per) <= REF_CYCLES));
      check($sformatf("refresh_int_m%0d_c%0d", mode, k), {31'b0, refresh_int}, {31'b0, exp_ri});
      check($sformatf("cmd_ready_m%0d_c%0d", mode, k), {31'b0, cmd_ready}, {31'b0, exp_rdy});
      if (refresh_int && (k > 1)) starts++;
    end
    $display("REF mode=%0d window=%0d cycles refresh-high cycles=%0d", mode, ncyc, starts);
  endtask

  initial begin
    int w;
    int r;
    logic [7:0] a;

    // 1. back-to-back writes then reads
    do_reset(2'b00);
    begin
      logic [7:0] wa [3];
      logic [7:0] wd [3];
      wa[0] = 8'h23; wa[1] = 8'h33; wa[2] = 8'h03;
      wd[0] = 8'h17; wd[1] = 8'h37; wd[2] = 8'hD7;
      for (int i = 0; i < 3; i++) begin
        user_data = {2'b01, wa[i], wd[i]};
        cmd_valid = 1'b1;
        #1;
        check("b2b_ready", {31'b0, cmd_ready}, 32'd1);
        if (!mdl_valid[wa[i]]) written_q.push_back(wa[i]);
        mdl_mem[wa[i]] = wd[i];
        mdl_valid[wa[i]] = 1'b1;
        $display("WR  b2b addr %02h <= %02h", wa[i], wd[i]);
        @(negedge clk);
      end
      cmd_valid = 1'b0;
    end
    issue(2'b10, 4'd2, 4'd3, 8'h00, w);
    issue(2'b10, 4'd3, 4'd3, 8'h00, w);
    issue(2'b10, 4'd0, 4'd3, 8'h00, w);
    check("t1_read_d7", {24'b0, user_out}, 32'hD7);

    // 2. refresh timing per clk_mode
    for (int m = 0; m < 4; m++) begin
      do_reset(m[1:0]);
      ref_window(m, (m == 3) ? 500 : 300);
    end
    // mode change mid-interval: 10 -> 00 at cycle 100, counter already past new limit
    do_reset(2'b10);
    for (int k = 1; k <= 180; k++) begin
      bit e;
      @(negedge clk);
      if (k == 100) clk_mode = 2'b00;
      #1;
      e = ((k >= 102) && (k <= 105)) || ((k >= 166) && (k <= 169));
      check($sformatf("refresh_int_modechg_c%0d", k), {31'b0, refresh_int}, {31'b0, e});
    end
    $display("REF mode change 10->00 window checked");

    // 3. read presented the cycle pending rises waits for the refresh
    do_reset(2'b00);
    repeat (REF_PERIOD) @(negedge clk);
    issue(2'b10, 4'd3, 4'd3, 8'h00, w);
    check("t3_wait_for_refresh", w, REF_CYCLES + 1);

    // 4. power-down aborts an in-flight read
    issue(2'b01, 4'd9, 4'd3, 8'h96, w);
    user_data = {2'b10, 4'd9, 4'd3, 8'h00};
    cmd_valid = 1'b1;
    wait_ready(w);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    power_enable = 1'b0;
    #1;
    check("pd_rd_valid_c0", {31'b0, rd_valid}, 32'd0);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("pd_rd_valid_c%0d", i), {31'b0, rd_valid}, 32'd0);
      check($sformatf("pd_refresh_int_c%0d", i), {31'b0, refresh_int}, 32'd0);
      check($sformatf("pd_cmd_ready_c%0d", i), {31'b0, cmd_ready}, 32'd0);
      check($sformatf("pd_user_out_c%0d", i), {24'b0, user_out}, {24'b0, mdl_last_rd});
    end
    $display("PWRDN 200 cycles during read");
    @(negedge clk);
    power_enable = 1'b1;
    issue(2'b10, 4'd9, 4'd3, 8'h00, w);
    check("t4_read_96", {24'b0, user_out}, 32'h96);

    // 5. contents survive reset
    issue(2'b01, 4'd15, 4'd15, 8'hA5, w);
    do_reset(2'b00);
    issue(2'b10, 4'd15, 4'd15, 8'h00, w);
    check("t5_read_a5", {24'b0, user_out}, 32'hA5);

    // 6. illegal ops and chip-enable gating
    issue(2'b11, 4'd2, 4'd3, 8'hFF, w);
    issue(2'b00, 4'd0, 4'd3, 8'h00, w);
    @(negedge clk);
    enable = 1'b0;
    user_data = {2'b01, 4'd2, 4'd3, 8'h55};
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("en0_cmd_ready_c%0d", i), {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    enable = 1'b1;
    $display("EN0 write held off for 20 cycles");
    issue(2'b10, 4'd2, 4'd3, 8'h00, w);
    check("t6_mem_unchanged", {24'b0, user_out}, 32'h17);
    issue(2'b10, 4'd0, 4'd3, 8'h00, w);

    // 7. randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 19) == 0) clk_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        enable = 1'b1;
      end
      r = $urandom_range(0, 9);
      a = 8'($urandom);
      if (r < 5 || written_q.size() == 0) begin
        issue(2'b01, a[7:4], a[3:0], 8'($urandom), w);
      end else if (r < 9) begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        issue(2'b10, a[7:4], a[3:0], 8'h00, w);
      end else begin
        issue(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, a[7:4], a[3:0], 8'($urandom), w);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
